// File: rtl/dac_spi_tx.sv
// Serial DAC transmitter: 12-bit sample plus 4-bit control nibble, shifted MSB-first under CS.
// Optional macro DAC_TX_FRAME_CNT_EN adds an 8-bit completed-frame counter output.
module dac_spi_tx #(
  parameter logic [3:0] CTRL_BITS  = 4'b0000,
  parameter int         GAP_CYCLES = 2          // legal range 1..255
) (
  input  logic        SCLK,
  input  logic        reset,
  input  logic        tx_en,
  input  logic [11:0] data_in,
  output logic        ready,
  output logic        SDO,
  output logic        CS,
  output logic        tx_done_tick
`ifdef DAC_TX_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  // Handshake: a frame starts on the rising edge where ready=1 and tx_en=1;
  // tx_en seen while ready=0 is dropped, never queued.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        cs_q, cs_d;
  logic        sdo_q, sdo_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [15:0] frame_w;

  assign frame_w = {CTRL_BITS, data_in};

  always_ff @(posedge SCLK) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cs_q      <= 1'b1;
      sdo_q     <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cs_q      <= cs_d;
      sdo_q     <= sdo_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_d      = cs_q;
    sdo_d     = sdo_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_en) begin
          shift_d   = frame_w;
          sdo_d     = frame_w[15];
          cs_d      = 1'b0;
          ready_d   = 1'b0;
          bit_cnt_d = 4'd15;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // bit_cnt counts bits still to present after the MSB went out on the accept edge
        if (bit_cnt_q != 4'd0) begin
          sdo_d     = shift_q[14];
          shift_d   = {shift_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
        end else begin
          cs_d      = 1'b1;
          sdo_d     = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = GAP_LOAD;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'd0) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sdo_d   = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign ready        = ready_q;
  assign SDO          = sdo_q;
  assign CS           = cs_q;
  assign tx_done_tick = done_q;

`ifdef DAC_TX_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Advances with tx_done_tick, so aborted frames are never counted.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (done_d) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge SCLK) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: one instance with CTRL=0011/GAP=2 and one with GAP=1.
// Frame counter checks run only when DAC_TX_FRAME_CNT_EN is defined.
module tb_dac_spi_tx;

  logic        SCLK = 1'b0;
  logic        reset;
  logic        tx_en, tx_en2;
  logic [11:0] data_in, data_in2;
  logic        ready, SDO, CS, tx_done_tick;
  logic        ready2, SDO2, CS2, done2;
`ifdef DAC_TX_FRAME_CNT_EN
  logic [7:0]  frame_cnt, frame_cnt2;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  always #5 SCLK = ~SCLK;

  dac_spi_tx #(.CTRL_BITS(4'b0011), .GAP_CYCLES(2)) dut (
    .SCLK(SCLK), .reset(reset), .tx_en(tx_en), .data_in(data_in),
    .ready(ready), .SDO(SDO), .CS(CS), .tx_done_tick(tx_done_tick)
`ifdef DAC_TX_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  dac_spi_tx #(.CTRL_BITS(4'b0000), .GAP_CYCLES(1)) dut_g1 (
    .SCLK(SCLK), .reset(reset), .tx_en(tx_en2), .data_in(data_in2),
    .ready(ready2), .SDO(SDO2), .CS(CS2), .tx_done_tick(done2)
`ifdef DAC_TX_FRAME_CNT_EN
    , .frame_cnt(frame_cnt2)
`endif
  );

  // Outputs are sampled 1 time unit after each rising edge; inputs change there too.
  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  // Called just after the accepting edge; returns the 16 SDO bits and CS-high count.
  task automatic capture(input bit sel, output logic [15:0] f, output int cs_bad);
    cs_bad = 0;
    f[15] = sel ? SDO2 : SDO;
    if ((sel ? CS2 : CS) !== 1'b0) cs_bad++;
    for (int i = 14; i >= 0; i--) begin
      tick();
      f[i] = sel ? SDO2 : SDO;
      if ((sel ? CS2 : CS) !== 1'b0) cs_bad++;
    end
  endtask

  task automatic wait_ready(input bit sel, input int bound);
    int n = 0;
    while ((sel ? ready2 : ready) !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    if ((sel ? ready2 : ready) !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", sel ? ready2 : ready, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) tick();
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_state: {CS,SDO,ready,done}=%b required 1010", {CS, SDO, ready, tx_done_tick});
    end
    vectors++;
    if ({CS2, SDO2, ready2, done2} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_state_g1: {CS,SDO,ready,done}=%b required 1010", {CS2, SDO2, ready2, done2});
    end
    reset = 1'b0;
    tick();
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1010) begin
      miscompares++;
      $display("FAIL idle_after_reset: {CS,SDO,ready,done}=%b required 1010", {CS, SDO, ready, tx_done_tick});
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] f;
    int bad;
    data_in = 12'hA5C;
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    capture(1'b0, f, bad);
    vectors++;
    if (f !== 16'h3A5C) begin
      miscompares++;
      $display("FAIL basic_bits: got %h required 3a5c", f);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL basic_cs_low: %0d of 16 cycles had CS high, required 0", bad);
    end
    tick();
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1001) begin
      miscompares++;
      $display("FAIL basic_k16: {CS,SDO,ready,done}=%b required 1001", {CS, SDO, ready, tx_done_tick});
    end
    tick();
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1000) begin
      miscompares++;
      $display("FAIL basic_k17: {CS,SDO,ready,done}=%b required 1000", {CS, SDO, ready, tx_done_tick});
    end
    tick();
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1010) begin
      miscompares++;
      $display("FAIL basic_k18: {CS,SDO,ready,done}=%b required 1010", {CS, SDO, ready, tx_done_tick});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f, e;
    int bad, n, hi;
    exp_q.push_back(16'h3001);
    exp_q.push_back(16'h3FFF);
    data_in = 12'h001;
    tx_en = 1'b1;
    tick();
    data_in = 12'hFFF;
    capture(1'b0, f, bad);
    e = exp_q.pop_front();
    vectors++;
    if (f !== e || bad != 0) begin
      miscompares++;
      $display("FAIL b2b_frame1: got %h (cs_bad %0d) required %h", f, bad, e);
    end
    n = 0;
    hi = 0;
    do begin
      tick();
      n++;
      if (CS === 1'b1) hi++;
    end while (CS !== 1'b0 && n < 40);
    tx_en = 1'b0;
    vectors++;
    if (15 + n != 19) begin
      miscompares++;
      $display("FAIL b2b_period: %0d cycles between CS falls, required 19", 15 + n);
    end
    vectors++;
    if (hi != 3) begin
      miscompares++;
      $display("FAIL b2b_gap: CS high %0d cycles, required 3", hi);
    end
    capture(1'b0, f, bad);
    e = exp_q.pop_front();
    vectors++;
    if (f !== e || bad != 0) begin
      miscompares++;
      $display("FAIL b2b_frame2: got %h (cs_bad %0d) required %h", f, bad, e);
    end
    wait_ready(1'b0, 10);
  endtask

  task automatic test_busy_ignore();
    logic [15:0] f;
    int dones, falls;
    logic prev;
    data_in = 12'h456;
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    f[15] = SDO;
    for (int i = 1; i <= 15; i++) begin
      if (i == 5) begin
        tx_en = 1'b1;
        data_in = 12'h123;
      end else begin
        tx_en = 1'b0;
      end
      tick();
      f[15 - i] = SDO;
    end
    tx_en = 1'b0;
    vectors++;
    if (f !== 16'h3456) begin
      miscompares++;
      $display("FAIL busy_bits: got %h required 3456", f);
    end
    dones = 0;
    falls = 0;
    prev = CS;
    repeat (40) begin
      tick();
      if (tx_done_tick === 1'b1) dones++;
      if (prev === 1'b1 && CS === 1'b0) falls++;
      prev = CS;
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL busy_done_count: %0d ticks, required 1", dones);
    end
    vectors++;
    if (falls != 0) begin
      miscompares++;
      $display("FAIL busy_extra_frame: %0d CS falls, required 0", falls);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [15:0] f;
    int bad, dones;
    data_in = 12'h777;
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1010) begin
      miscompares++;
      $display("FAIL abort_state: {CS,SDO,ready,done}=%b required 1010", {CS, SDO, ready, tx_done_tick});
    end
    dones = 0;
    repeat (25) begin
      tick();
      if (tx_done_tick === 1'b1 || CS === 1'b0) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: %0d cycles with done or CS low, required 0", dones);
    end
    data_in = 12'h5A5;
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    capture(1'b0, f, bad);
    vectors++;
    if (f !== 16'h35A5 || bad != 0) begin
      miscompares++;
      $display("FAIL abort_next_frame: got %h (cs_bad %0d) required 35a5", f, bad);
    end
    tick();
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1001) begin
      miscompares++;
      $display("FAIL abort_next_done: {CS,SDO,ready,done}=%b required 1001", {CS, SDO, ready, tx_done_tick});
    end
    wait_ready(1'b0, 5);
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    tx_en = 1'b1;
    data_in = 12'hFFF;
    tick();
    reset = 1'b0;
    tx_en = 1'b0;
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_wins: {CS,SDO,ready,done}=%b required 1010", {CS, SDO, ready, tx_done_tick});
    end
    tick();
    vectors++;
    if ({CS, SDO, ready, tx_done_tick} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_wins_after: {CS,SDO,ready,done}=%b required 1010", {CS, SDO, ready, tx_done_tick});
    end
  endtask

  task automatic test_gap_one();
    logic [15:0] f;
    int bad, n;
    bit seen_hi;
    data_in2 = 12'hABC;
    tx_en2 = 1'b1;
    tick();
    tx_en2 = 1'b0;
    capture(1'b1, f, bad);
    vectors++;
    if (f !== 16'h0ABC || bad != 0) begin
      miscompares++;
      $display("FAIL g1_bits: got %h (cs_bad %0d) required 0abc", f, bad);
    end
    tick();
    vectors++;
    if ({CS2, SDO2, ready2, done2} !== 4'b1001) begin
      miscompares++;
      $display("FAIL g1_k16: {CS,SDO,ready,done}=%b required 1001", {CS2, SDO2, ready2, done2});
    end
    tick();
    vectors++;
    if ({CS2, SDO2, ready2, done2} !== 4'b1010) begin
      miscompares++;
      $display("FAIL g1_k17: {CS,SDO,ready,done}=%b required 1010", {CS2, SDO2, ready2, done2});
    end
    tx_en2 = 1'b1;
    tick();
    n = 0;
    seen_hi = 1'b0;
    do begin
      tick();
      n++;
      if (CS2 === 1'b1) seen_hi = 1'b1;
    end while (!(seen_hi && CS2 === 1'b0) && n < 60);
    tx_en2 = 1'b0;
    vectors++;
    if (n != 18) begin
      miscompares++;
      $display("FAIL g1_period: %0d cycles between CS falls, required 18", n);
    end
    wait_ready(1'b1, 30);
  endtask

`ifdef DAC_TX_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int dones, n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL cnt_reset: frame_cnt=%0d required 0", frame_cnt);
    end
    data_in = 12'h3C3;
    tx_en = 1'b1;
    dones = 0;
    n = 0;
    while (dones < 257 && n < 6000) begin
      tick();
      n++;
      if (tx_done_tick === 1'b1) begin
        dones++;
        if (dones == 256) begin
          vectors++;
          if (frame_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL cnt_wrap: frame_cnt=%0d after 256 frames, required 0", frame_cnt);
          end
        end
      end
    end
    tx_en = 1'b0;
    wait_ready(1'b0, 10);
    vectors++;
    if (dones != 257 || frame_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL cnt_257: frames=%0d frame_cnt=%0d required 257 and 1", dones, frame_cnt);
    end
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL cnt_abort: frame_cnt=%0d required 0", frame_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    tx_en = 1'b0;
    tx_en2 = 1'b0;
    data_in = '0;
    data_in2 = '0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_busy_ignore();
    test_mid_frame_reset();
    test_reset_priority();
    test_gap_one();
`ifdef DAC_TX_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Serial transmitter for the DAC side of the converter datapath. It is the transmit counterpart to the 16-bit serial ADC receive path.
- Accepts a 12-bit sample via a one-cycle handshake and prepends a 4-bit control nibble.
- Shifts the 16-bit frame MSB-first on SDO, with CS held low for exactly 16 SCLK cycles.
- Signals completion with a one-cycle tick.
- Enforces a programmable inter-frame gap, so back-to-back samples meet the DAC's CS-high time.

Parameters:
- CTRL_BITS, 4'b0000: control nibble sent as frame bits [15:12].
- GAP_CYCLES, 2: SCLK cycles from the done edge until ready reasserts. Legal range 1..255; 0 is illegal.

Ports:
- SCLK  input  1  system/serial clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_en  input  1  start request; sampled only when ready=1.
- data_in  input  12  sample to transmit; captured on the accepting edge.
- ready  output  1  high when idle and able to accept tx_en.
- SDO  output  1  serial data to the DAC; changes on the SCLK rising edge, so it is stable at the falling edge.
- CS  output  1  active-low frame select.
- tx_done_tick  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: CS=1, SDO=0, ready=1, tx_done_tick=0, state IDLE, shift register 0, counters 0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - On an edge k with tx_en=1, the block loads shift_reg={CTRL_BITS,data_in[11:0]}.
  - At that same edge: CS<=0, SDO<=frame[15], ready<=0, bit counter<=15, state -> SHIFT.
- SHIFT:
  - Edges k+1..k+15 drive SDO with frame[14]..frame[0], one bit per edge, MSB-first.
  - At edge k+16: CS<=1, SDO<=0, tx_done_tick<=1, gap counter<=GAP_CYCLES-1, state -> GAP.
  - CS is therefore low for exactly 16 cycles.
- GAP:
  - tx_done_tick clears at edge k+17.
  - The gap counter decrements each edge. When it reads 0, ready<=1 and state -> IDLE.
  - ready reasserts at edge k+16+GAP_CYCLES.
- Frame length: k..k+16+GAP_CYCLES. With tx_en held high continuously, back-to-back frames start every 16+GAP_CYCLES+1 cycles (19 at default).
- tx_en while ready=0: ignored, not queued.
- data_in changes after the accepting edge: no effect on the frame in flight.
- reset during SHIFT or GAP: on the next edge all outputs take reset values. The frame is aborted, no tx_done_tick is issued, and no partial frame resumes.
- reset and tx_en on the same edge: reset wins; no frame starts.
- Width rules:
  - Bit counter: 4 bits.
  - Gap counter: 8 bits.
  - data_in is never truncated or padded; the frame is always exactly 16 bits.

Optional Feature:
- Macro: DAC_TX_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [7:0], reset to 0.
  - Increments on the same edge that asserts tx_done_tick, wrapping 255->0.
  - Not incremented for aborted frames.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame:
  - Stimulus: reset 5 cycles, then tx_en=1 for one cycle with data_in=12'hA5C, CTRL_BITS=4'b0011.
  - Response: 16 cycles of CS=0 with SDO sequence 0011_1010_0101_1100.
  - tx_done_tick high exactly 1 cycle at k+16, with CS=1.
  - ready=1 at k+18.
- Back-to-back:
  - Stimulus: tx_en held high with data_in=12'h001, then 12'hFFF.
  - Response: second CS falling edge exactly 19 cycles after the first.
  - Second frame bits [11:0] all 1.
  - Gap of CS=1 lasts 3 cycles.
- Busy ignore:
  - Stimulus: pulse tx_en at k+5 with data_in=12'h123 during a frame carrying 12'h456.
  - Response: the frame still carries 12'h456, no extra frame follows, and only one tx_done_tick occurs.
- Mid-frame reset:
  - Stimulus: assert reset at k+8 for 1 cycle.
  - Response: at the next edge CS=1, SDO=0, ready=1; no tx_done_tick.
  - A subsequent tx_en produces a clean, full 16-bit frame.
- Parameter edge:
  - Stimulus: GAP_CYCLES=1.
  - Response: ready at k+17 and back-to-back frame period of 18 cycles.
- Optional counter (DAC_TX_FRAME_CNT_EN defined):
  - Stimulus: send 257 frames, then abort one frame with reset.
  - Response: frame_cnt reads 1 after the 257 frames (255->0 wrap observed).
  - After the abort, frame_cnt is 0 because reset clears it.
